// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: FSM state encoding and the
// op-code values also used when generating the alu_lo/alu_hi ROM images.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;

    // Counter preload: SETTLE lasts exactly wait_cycles clock cycles.
    function automatic logic [3:0] settle_init(input int wait_cycles);
        return 4'(wait_cycles - 1);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bus of the ALU sequencer.
// Both channels use valid/ready: a transfer happens on a rising clk edge where
// valid & ready are both high; valid never waits for ready, payload is stable while valid & !ready.
interface alu_seq_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [3:0] req_op;
    logic       req_invert;
    logic       req_carry;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_zero;

    modport master (
        output req_valid, req_a, req_b, req_op, req_invert, req_carry, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_invert, req_carry, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
    );
endinterface

// File: rtl/alu_seq.sv
// Sequencer in front of the EEPROM ALU pair: latches a request onto the ROM
// address pins, holds output-enable low for WAIT_CYCLES, then captures the result.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WAIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    alu_seq_if.slave   bus,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    output logic       alu_invert,
    output logic       alu_carry_in,
    output logic       alu_n_oe,
    input  logic [7:0] alu_result,
    input  logic       alu_n_carry,
    output state_t     dbg_state
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("alu_seq: WAIT_CYCLES must be in 1..15");
    end

    localparam logic [3:0] CNT_INIT = settle_init(WAIT_CYCLES);

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic       ready_c;
    logic       load;
    logic       capture;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready_c  = 1'b0;
        load     = 1'b0;
        capture  = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid) begin
                    load     = 1'b1;
                    state_nx = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == 4'd0) begin
                    capture  = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                // Consuming the response frees the slot for a new request in the same cycle.
                ready_c = bus.rsp_ready;
                if (bus.rsp_ready) begin
                    if (bus.req_valid) begin
                        load     = 1'b1;
                        state_nx = ST_SETTLE;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus.req_ready = ready_c & n_rst;
    assign bus.rsp_valid = (state == ST_DONE);
    assign dbg_state     = state;

    // alu_result is only sampled in the capture cycle, so a floating bus never reaches rsp_*.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            alu_a          <= 8'h00;
            alu_b          <= 8'h00;
            alu_op         <= 4'h0;
            alu_invert     <= 1'b0;
            alu_carry_in   <= 1'b0;
            alu_n_oe       <= 1'b1;
            cnt            <= 4'd0;
            bus.rsp_result <= 8'h00;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_zero   <= 1'b0;
        end else begin
            alu_n_oe <= (state_nx != ST_SETTLE);
            if (load) begin
                alu_a        <= bus.req_a;
                alu_b        <= bus.req_b;
                alu_op       <= bus.req_op;
                alu_invert   <= bus.req_invert;
                alu_carry_in <= bus.req_carry;
                cnt          <= CNT_INIT;
            end else if (state == ST_SETTLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                bus.rsp_result <= alu_result;
                bus.rsp_carry  <= ~alu_n_carry;
                bus.rsp_zero   <= (alu_result == 8'h00);
            end
        end
    end

endmodule
